// File: rtl/ccff_chain_loader_if.sv
// Bitstream word channel between the host and the configuration-chain loader.
// The host drives data/valid; the loader answers with ready.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input  cfg_ready);
    modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Feeds bitstream words serially into a cleared configuration chain (ccff_head)
// and flags any non-zero bit returning on ccff_tail while the chain is loaded.
module ccff_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 42,
    parameter int CLR_CYC   = 4
) (
    input  logic                 prog_clk,
    input  logic                 pReset_n,
    input  logic                 start,
    ccff_chain_loader_if.slave   cfg,
    output logic                 fab_pReset,
    output logic                 prog_clk_en,
    output logic                 ccff_head,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - WORD_W * (NUM_WORDS - 1);
    localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
    localparam int BCNT_W    = $clog2(WORD_W + 1);
    localparam int CLR_W     = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(CHAIN_LEN - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic [WCNT_W-1:0] WORD_ALL   = WCNT_W'(NUM_WORDS);
    localparam logic [WCNT_W-1:0] WORD_FINAL = WCNT_W'(NUM_WORDS - 1);
    localparam logic [WCNT_W-1:0] WORD_ONE   = WCNT_W'(1);
    localparam logic [BCNT_W-1:0] BUF_FULL   = BCNT_W'(WORD_W);
    localparam logic [BCNT_W-1:0] BUF_LAST   = BCNT_W'(LAST_BITS);
    localparam logic [BCNT_W-1:0] BUF_ONE    = BCNT_W'(1);
    localparam logic [CLR_W-1:0]  CLR_LAST   = CLR_W'(CLR_CYC - 1);
    localparam logic [CLR_W-1:0]  CLR_ONE    = CLR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [WORD_W-1:0] buf_q,      buf_d;
    logic [BCNT_W-1:0] buf_cnt_q,  buf_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CLR_W-1:0]  clr_cnt_q,  clr_cnt_d;
    logic              err_q,      err_d;

    logic shift_en;
    logic xfer;

    // Enables and ready are decoded purely from flops so the fabric clock gate sees a clean signal.
    assign shift_en      = (state_q == S_SHIFT) && (buf_cnt_q != '0);
    assign cfg.cfg_ready = (state_q == S_SHIFT) && (buf_cnt_q <= BUF_ONE) && (word_cnt_q < WORD_ALL);
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

    assign prog_clk_en = shift_en;
    assign ccff_head   = buf_q[WORD_W-1];
    assign fab_pReset  = (state_q == S_CLEAR);
    assign busy        = (state_q == S_CLEAR) || (state_q == S_SHIFT);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;

    always_comb begin
        // NOTE: every next-state signal takes its held value first so no path infers a latch.
        state_d    = state_q;
        buf_d      = buf_q;
        buf_cnt_d  = buf_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    buf_d      = '0;
                    buf_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    clr_cnt_d  = '0;
                    err_d      = 1'b0;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) state_d = S_SHIFT;
                else                       clr_cnt_d = clr_cnt_q + CLR_ONE;
            end
            S_SHIFT: begin
                if (shift_en) begin
                    buf_d     = buf_q << 1;
                    buf_cnt_d = buf_cnt_q - BUF_ONE;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    if (ccff_tail)              err_d   = 1'b1;
                    if (bit_cnt_q == BIT_LAST)  state_d = S_DONE;
                end
                // A refill on the last buffered bit replaces the shift: the bit still leaves on head.
                if (xfer) begin
                    buf_d      = cfg.cfg_data;
                    buf_cnt_d  = (word_cnt_q == WORD_FINAL) ? BUF_LAST : BUF_FULL;
                    word_cnt_d = word_cnt_q + WORD_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            buf_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            clr_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_cnt_q  <= buf_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule
